// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// The master side is dispatch/CDB/ALU; the slave side is the reservation station.
interface alu_rs_scheduler_if #(
    parameter int ROB_W = 4
);
    logic             disp_sgn;
    logic [5:0]       disp_opcode;
    logic [31:0]      disp_Vj;
    logic [31:0]      disp_Vk;
    logic [ROB_W-1:0] disp_Qj;
    logic [ROB_W-1:0] disp_Qk;
    logic             disp_Qj_busy;
    logic             disp_Qk_busy;
    logic [31:0]      disp_imm;
    logic [31:0]      disp_pc;
    logic [ROB_W-1:0] disp_rob;
    logic             rs_full;

    logic             cdb_alu_sgn;
    logic [ROB_W-1:0] cdb_alu_rob;
    logic [31:0]      cdb_alu_val;
    logic             cdb_lsb_sgn;
    logic [ROB_W-1:0] cdb_lsb_rob;
    logic [31:0]      cdb_lsb_val;

    // Issue side: RS_sgn is a one-cycle "op valid" with no back-pressure;
    // the ALU is combinational and always accepts what is presented.
    logic             RS_sgn;
    logic [5:0]       RS_opcode;
    logic [31:0]      lhs;
    logic [31:0]      rhs;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] ROB_entry;

    modport master (
        output disp_sgn, disp_opcode, disp_Vj, disp_Vk, disp_Qj, disp_Qk,
               disp_Qj_busy, disp_Qk_busy, disp_imm, disp_pc, disp_rob,
               cdb_alu_sgn, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_val,
        input  rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
    );

    modport slave (
        input  disp_sgn, disp_opcode, disp_Vj, disp_Vk, disp_Qj, disp_Qk,
               disp_Qj_busy, disp_Qk_busy, disp_imm, disp_pc, disp_rob,
               cdb_alu_sgn, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_val,
        output rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers ops, wakes operands from both CDBs, issues lowest ready entry.
// Optional ALU_RS_BYPASS_EN forwards same-cycle CDB wakeup directly into select.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    alu_rs_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_valid, r_qj_busy, r_qk_busy;
    logic [5:0]         r_op  [RS_SIZE];
    logic [31:0]        r_vj  [RS_SIZE];
    logic [31:0]        r_vk  [RS_SIZE];
    logic [31:0]        r_imm [RS_SIZE];
    logic [31:0]        r_pc  [RS_SIZE];
    logic [ROB_W-1:0]   r_qj  [RS_SIZE];
    logic [ROB_W-1:0]   r_qk  [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];

    logic               r_sgn, r_full;
    logic [5:0]         r_out_op;
    logic [31:0]        r_lhs, r_rhs, r_out_imm, r_out_pc;
    logic [ROB_W-1:0]   r_out_rob;

    logic [RS_SIZE-1:0] w_qj_busy_nx, w_qk_busy_nx, w_ready, w_valid_nx;
    logic [31:0]        w_vj_nx [RS_SIZE];
    logic [31:0]        w_vk_nx [RS_SIZE];
    logic               w_iss, w_disp_free, w_disp;
    logic [IDX_W-1:0]   w_iss_idx, w_disp_idx;
    logic               w_dj_busy, w_dk_busy;
    logic [31:0]        w_dvj, w_dvk;
    logic [IDX_W:0]     w_free_cnt;
    logic               w_full_nx;

    // Per-entry wakeup; ALU and LSB may each resolve a different operand of one entry.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_vj_nx[i]      = r_vj[i];
            w_vk_nx[i]      = r_vk[i];
            w_qj_busy_nx[i] = r_qj_busy[i];
            w_qk_busy_nx[i] = r_qk_busy[i];
            if (r_qj_busy[i] && bus.cdb_alu_sgn && r_qj[i] == bus.cdb_alu_rob) begin
                w_vj_nx[i]      = bus.cdb_alu_val;
                w_qj_busy_nx[i] = 1'b0;
            end else if (r_qj_busy[i] && bus.cdb_lsb_sgn && r_qj[i] == bus.cdb_lsb_rob) begin
                w_vj_nx[i]      = bus.cdb_lsb_val;
                w_qj_busy_nx[i] = 1'b0;
            end
            if (r_qk_busy[i] && bus.cdb_alu_sgn && r_qk[i] == bus.cdb_alu_rob) begin
                w_vk_nx[i]      = bus.cdb_alu_val;
                w_qk_busy_nx[i] = 1'b0;
            end else if (r_qk_busy[i] && bus.cdb_lsb_sgn && r_qk[i] == bus.cdb_lsb_rob) begin
                w_vk_nx[i]      = bus.cdb_lsb_val;
                w_qk_busy_nx[i] = 1'b0;
            end
        end
    end

`ifdef ALU_RS_BYPASS_EN
    assign w_ready = r_valid & ~w_qj_busy_nx & ~w_qk_busy_nx;
`else
    assign w_ready = r_valid & ~r_qj_busy & ~r_qk_busy;
`endif

    // Descending scan leaves the lowest index in both the issue and the free-slot pick.
    always_comb begin
        w_iss       = 1'b0;
        w_iss_idx   = '0;
        w_disp_free = 1'b0;
        w_disp_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_iss     = 1'b1;
                w_iss_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_disp_free = 1'b1;
                w_disp_idx  = IDX_W'(i);
            end
        end
    end

    assign w_disp = bus.disp_sgn && w_disp_free;

    always_comb begin
        w_dvj     = bus.disp_Vj;
        w_dvk     = bus.disp_Vk;
        w_dj_busy = bus.disp_Qj_busy;
        w_dk_busy = bus.disp_Qk_busy;
        if (bus.disp_Qj_busy && bus.cdb_alu_sgn && bus.disp_Qj == bus.cdb_alu_rob) begin
            w_dvj     = bus.cdb_alu_val;
            w_dj_busy = 1'b0;
        end else if (bus.disp_Qj_busy && bus.cdb_lsb_sgn && bus.disp_Qj == bus.cdb_lsb_rob) begin
            w_dvj     = bus.cdb_lsb_val;
            w_dj_busy = 1'b0;
        end
        if (bus.disp_Qk_busy && bus.cdb_alu_sgn && bus.disp_Qk == bus.cdb_alu_rob) begin
            w_dvk     = bus.cdb_alu_val;
            w_dk_busy = 1'b0;
        end else if (bus.disp_Qk_busy && bus.cdb_lsb_sgn && bus.disp_Qk == bus.cdb_lsb_rob) begin
            w_dvk     = bus.cdb_lsb_val;
            w_dk_busy = 1'b0;
        end
    end

    always_comb begin
        w_valid_nx = r_valid;
        if (w_iss)  w_valid_nx[w_iss_idx]  = 1'b0;
        if (w_disp) w_valid_nx[w_disp_idx] = 1'b1;
        w_free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++)
            w_free_cnt = w_free_cnt + (IDX_W + 1)'(~w_valid_nx[i]);
        w_full_nx = (w_free_cnt <= (IDX_W + 1)'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            r_sgn     <= 1'b0;
            r_full    <= 1'b0;
            r_out_op  <= '0;
            r_lhs     <= '0;
            r_rhs     <= '0;
            r_out_imm <= '0;
            r_out_pc  <= '0;
            r_out_rob <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_valid   <= '0;
                r_sgn     <= 1'b0;
                r_full    <= 1'b0;
                r_out_op  <= '0;
                r_lhs     <= '0;
                r_rhs     <= '0;
                r_out_imm <= '0;
                r_out_pc  <= '0;
                r_out_rob <= '0;
            end else begin
                r_valid   <= w_valid_nx;
                r_qj_busy <= w_qj_busy_nx;
                r_qk_busy <= w_qk_busy_nx;
                if (w_disp) begin
                    r_qj_busy[w_disp_idx] <= w_dj_busy;
                    r_qk_busy[w_disp_idx] <= w_dk_busy;
                end
                r_full <= w_full_nx;
                r_sgn  <= w_iss;
                if (w_iss) begin
                    r_out_op  <= r_op[w_iss_idx];
                    r_lhs     <= w_vj_nx[w_iss_idx];
                    r_rhs     <= w_vk_nx[w_iss_idx];
                    r_out_imm <= r_imm[w_iss_idx];
                    r_out_pc  <= r_pc[w_iss_idx];
                    r_out_rob <= r_rob[w_iss_idx];
                end else begin
                    r_out_op  <= '0;
                    r_lhs     <= '0;
                    r_rhs     <= '0;
                    r_out_imm <= '0;
                    r_out_pc  <= '0;
                    r_out_rob <= '0;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_vj[i] <= w_vj_nx[i];
                r_vk[i] <= w_vk_nx[i];
            end
            if (w_disp) begin
                r_op[w_disp_idx]  <= bus.disp_opcode;
                r_vj[w_disp_idx]  <= w_dvj;
                r_vk[w_disp_idx]  <= w_dvk;
                r_qj[w_disp_idx]  <= bus.disp_Qj;
                r_qk[w_disp_idx]  <= bus.disp_Qk;
                r_imm[w_disp_idx] <= bus.disp_imm;
                r_pc[w_disp_idx]  <= bus.disp_pc;
                r_rob[w_disp_idx] <= bus.disp_rob;
            end
        end
    end

    assign bus.RS_sgn    = r_sgn;
    assign bus.rs_full   = r_full;
    assign bus.RS_opcode = r_out_op;
    assign bus.lhs       = r_lhs;
    assign bus.rhs       = r_rhs;
    assign bus.imm       = r_out_imm;
    assign bus.pc        = r_out_pc;
    assign bus.ROB_entry = r_out_rob;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: expected issues (with their issue cycle) are queued by
// the stimulus and popped by an independent monitor whenever RS_sgn is seen.
`timescale 1ns/1ps
module tb_alu_rs_scheduler;
    localparam int ROB_W = 4;
    localparam int W     = 170;
`ifdef ALU_RS_BYPASS_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 1;
`endif
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd10;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rdy   = 1'b1;
    logic flush = 1'b0;

    alu_rs_scheduler_if #(.ROB_W(ROB_W)) bus ();

    alu_rs_scheduler #(.RS_SIZE(16), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int   cyc       = 0;
    logic edge_live = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        edge_live <= rdy && !rst;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, expv);
    endtask

    function automatic logic [W-1:0] rec(input int c, input logic [5:0] op,
                                         input logic [31:0] l, input logic [31:0] r,
                                         input logic [31:0] i, input logic [31:0] p,
                                         input logic [ROB_W-1:0] rob);
        return {32'(c), op, l, r, i, p, rob};
    endfunction

    task automatic expect_issue(input int c, input logic [5:0] op, input logic [31:0] l,
                                input logic [31:0] r, input logic [31:0] i,
                                input logic [31:0] p, input int rob);
        exp_q.push_back(rec(c, op, l, r, i, p, ROB_W'(rob)));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (edge_live && !rst) begin
            if (bus.RS_sgn) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_issue: got rob %0d at cycle %0d, expected no issue",
                             bus.ROB_entry, cyc);
                end else begin
                    chk("issue", rec(cyc, bus.RS_opcode, bus.lhs, bus.rhs, bus.imm, bus.pc,
                                     bus.ROB_entry), exp_q.pop_front());
                end
            end else begin
                chk("idle_outputs", W'({bus.RS_opcode, bus.lhs, bus.rhs, bus.imm, bus.pc,
                                        bus.ROB_entry}), '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.disp_sgn    = 1'b0;
        bus.cdb_alu_sgn = 1'b0;
        bus.cdb_lsb_sgn = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, input int qj, input int qjb,
                        input logic [31:0] vk, input int qk, input int qkb,
                        input logic [31:0] imm, input logic [31:0] pc, input int rob);
        bus.disp_sgn     = 1'b1;
        bus.disp_opcode  = op;
        bus.disp_Vj      = vj;
        bus.disp_Qj      = ROB_W'(qj);
        bus.disp_Qj_busy = (qjb != 0);
        bus.disp_Vk      = vk;
        bus.disp_Qk      = ROB_W'(qk);
        bus.disp_Qk_busy = (qkb != 0);
        bus.disp_imm     = imm;
        bus.disp_pc      = pc;
        bus.disp_rob     = ROB_W'(rob);
    endtask

    task automatic cdb_alu(input int rob, input logic [31:0] val);
        bus.cdb_alu_sgn = 1'b1;
        bus.cdb_alu_rob = ROB_W'(rob);
        bus.cdb_alu_val = val;
    endtask

    task automatic cdb_lsb(input int rob, input logic [31:0] val);
        bus.cdb_lsb_sgn = 1'b1;
        bus.cdb_lsb_rob = ROB_W'(rob);
        bus.cdb_lsb_val = val;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int n;
        idle_inputs();
        disp(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.disp_sgn = 1'b0;
        bus.cdb_alu_rob = '0; bus.cdb_alu_val = '0;
        bus.cdb_lsb_rob = '0; bus.cdb_lsb_val = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sgn", W'(bus.RS_sgn), '0);
        chk("reset_full", W'(bus.rs_full), '0);
        chk("reset_data", W'({bus.RS_opcode, bus.lhs, bus.rhs, bus.imm, bus.pc, bus.ROB_entry}), '0);
        rst = 1'b0;
        cycle();

        // Ready ADDI issues one edge after dispatch.
        disp(OP_ADDI, 5, 0, 0, 0, 0, 0, 7, 32'h100, 3);
        cycle();
        expect_issue(cyc + 1, OP_ADDI, 5, 0, 7, 32'h100, 3);
        repeat (2) cycle();

        // Wakeup via ALU CDB; a tag differing only in the MSB must not wake it.
        disp(OP_ADD, 0, 2, 1, 10, 0, 0, 0, 32'h104, 5);
        cycle();
        cdb_alu(10, 32'hdead);
        cycle();
        cdb_alu(2, 32'h20);
        cycle();
        expect_issue(cyc + EXTRA, OP_ADD, 32'h20, 10, 0, 32'h104, 5);
        repeat (3) cycle();

        // Both CDBs resolve one entry in the same cycle.
        disp(OP_SUB, 0, 1, 1, 0, 4, 1, 0, 32'h108, 6);
        cycle();
        cdb_alu(1, 9);
        cdb_lsb(4, 3);
        cycle();
        expect_issue(cyc + EXTRA, OP_SUB, 9, 3, 0, 32'h108, 6);
        repeat (3) cycle();

        // Dispatch captures operands from same-cycle broadcasts.
        disp(OP_ADD, 0, 8, 1, 0, 9, 1, 0, 32'h10c, 7);
        cdb_alu(8, 32'h11);
        cdb_lsb(9, 32'h22);
        cycle();
        expect_issue(cyc + 1, OP_ADD, 32'h11, 32'h22, 0, 32'h10c, 7);
        repeat (3) cycle();

        // Reset mid-run: waiting entries vanish, a later ADDI issues alone.
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 0, 7, 1, 0, 0, 0, 0, 32'h300 + 32'(4 * i), i);
            cycle();
        end
        disp(OP_ADDI, 1, 0, 0, 0, 0, 0, 2, 32'h310, 9);
        cycle();
        expect_issue(cyc + 1, OP_ADDI, 1, 0, 2, 32'h310, 9);
        cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_sgn", W'(bus.RS_sgn), '0);
        chk("midrst_full", W'(bus.rs_full), '0);
        chk("midrst_data", W'({bus.lhs, bus.imm, bus.ROB_entry}), '0);
        #1 rst = 1'b0;
        disp(OP_ADDI, 4, 0, 0, 0, 0, 0, 6, 32'h320, 10);
        cycle();
        expect_issue(cyc + 1, OP_ADDI, 4, 0, 6, 32'h320, 10);
        cycle();
        cdb_alu(7, 32'h55);
        cycle();
        repeat (3) cycle();

        // Fill 15 entries, then drain in index order with a 3-cycle freeze.
        for (int i = 0; i < 15; i++) begin
            disp(OP_ADD, 0, 7, 1, 32'(3 * i), 0, 0, 0, 32'h200 + 32'(4 * i), i);
            cycle();
            if (i == 13) chk("full_after_14", W'(bus.rs_full), '0);
            if (i == 14) chk("full_after_15", W'(bus.rs_full), W'(1));
        end
        cdb_alu(7, 32'h77);
        cycle();
        c0 = cyc;
        for (int i = 0; i < 15; i++) begin
            n = c0 + EXTRA + i;
            if (n > c0 + 2) n = n + 3;
            expect_issue(n, OP_ADD, 32'h77, 32'(3 * i), 0, 32'h200 + 32'(4 * i), i);
        end
        repeat (2) cycle();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("frozen_outputs", W'({bus.RS_sgn, bus.ROB_entry, bus.lhs}),
                W'({1'b1, ROB_W'(2 - EXTRA), 32'h77}));
        end
        rdy = 1'b1;
        repeat (16) cycle();
        chk("full_after_drain", W'(bus.rs_full), '0);

        // Flush a nearly full station while an issue and a dispatch are pending.
        for (int i = 0; i < 14; i++) begin
            disp(OP_ADD, 0, 3, 1, 0, 0, 0, 0, 32'h400 + 32'(4 * i), i);
            cycle();
        end
        disp(OP_ADDI, 1, 0, 0, 0, 0, 0, 1, 32'h440, 14);
        cycle();
        chk("full_before_flush", W'(bus.rs_full), W'(1));
        disp(OP_ADDI, 2, 0, 0, 0, 0, 0, 1, 32'h444, 15);
        flush = 1'b1;
        cycle();
        chk("flush_sgn", W'(bus.RS_sgn), '0);
        chk("flush_full", W'(bus.rs_full), '0);
        cdb_alu(3, 32'h33);
        cycle();
        repeat (4) cycle();

        // Station is usable again after flush.
        disp(OP_SUB, 8, 0, 0, 5, 0, 0, 0, 32'h420, 11);
        cycle();
        expect_issue(cyc + 1, OP_SUB, 8, 5, 0, 32'h420, 11);
        repeat (3) cycle();

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) cycle();
        chk("queue_drained", W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
